// File: rtl/icache_pkg.sv
// Shared types and size helpers for the instruction-cache refill path.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } refill_state_t;

    localparam int DEF_B      = 64;
    localparam int DEF_BEAT_W = 64;
    localparam int DEF_CNT_W  = 32;

    // Number of byte-offset bits stripped from a fetch address to block-align it.
    function automatic int block_bits(input int b);
        return $clog2(b);
    endfunction

    function automatic int rep_cycles(input int b, input int beat_w);
        return (b * 8) / beat_w;
    endfunction

    // One extra bit so the counter can hold the full beat count, not just count-1.
    function automatic int beat_cnt_w(input int b, input int beat_w);
        return $clog2(rep_cycles(b, beat_w)) + 1;
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Miss-driven line refill sequencer: block-aligned memory read, beat streaming
// into icache_l1 over RepReady/RepWord, and fetch stall until the line is in.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int B      = DEF_B,
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             L1IMiss,
    input  logic [31:0]      Address,
    input  logic [1:0]       PCSrcReg,
    input  logic             CacheRepActive,
    output logic             MemReq,
    output logic [31:0]      MemAddr,
    input  logic             MemGnt,
    input  logic             MemValid,
    input  logic [63:0]      MemData,
    output logic             RepReady,
    output logic [63:0]      RepWord,
    output logic             StallF,
    output logic             RefillDone,
    output logic [CNT_W-1:0] RefillCount
);

    localparam int LB         = block_bits(B);
    localparam int REP_CYCLES = rep_cycles(B, BEAT_W);
    localparam int BCW        = beat_cnt_w(B, BEAT_W);

    refill_state_t state_q, state_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]    mem_addr_q, mem_addr_d;
    logic           rep_ready_q, rep_ready_d;
    logic [63:0]    rep_word_q, rep_word_d;

    logic           miss_take;
    logic           unused_addr_bits;

    assign miss_take        = L1IMiss && (PCSrcReg == 2'b00);
    assign unused_addr_bits = ^Address[LB-1:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        mem_addr_d  = mem_addr_q;
        rep_ready_d = 1'b0;
        rep_word_d  = rep_word_q;
        case (state_q)
            IDLE: begin
                if (miss_take) begin
                    mem_addr_d = {Address[31:LB], {LB{1'b0}}};
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A grant wins over a same-cycle redirect: memory has committed to the beats.
                if (MemGnt) begin
                    state_d    = FILL;
                    beat_cnt_d = '0;
                end else if (PCSrcReg != 2'b00) begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (MemValid) begin
                    rep_ready_d = 1'b1;
                    rep_word_d  = MemData;
                    beat_cnt_d  = beat_cnt_q + BCW'(1);
                    if (beat_cnt_q == BCW'(REP_CYCLES - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            mem_addr_q  <= '0;
            rep_ready_q <= 1'b0;
            rep_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            mem_addr_q  <= mem_addr_d;
            rep_ready_q <= rep_ready_d;
            rep_word_q  <= rep_word_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_refill_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (state_q == DONE),
        .count_o(RefillCount)
    );

    assign MemReq     = (state_q == REQ);
    assign MemAddr    = mem_addr_q;
    assign RepReady   = rep_ready_q;
    assign RepWord    = rep_word_q;
    assign RefillDone = (state_q == DONE);
    // Stall asserts in the miss cycle itself so fetch never advances past the missing line.
    assign StallF     = !reset && ((state_q != IDLE) || miss_take);

    a_rep_active_idle: assert property (@(posedge clk) disable iff (reset)
        !((state_q == IDLE) && CacheRepActive && !rep_ready_q));

    a_valid_in_fill: assert property (@(posedge clk) disable iff (reset)
        MemValid |-> (state_q == FILL));

    a_beat_bound: assert property (@(posedge clk) disable iff (reset)
        beat_cnt_q <= BCW'(REP_CYCLES));

endmodule
